// File: rtl/freq_select_pkg.sv
// freq_select_pkg
//   Shared types and helpers for the frequency setpoint selector.
//   - btn_state_t : per-button auto-repeat state (IDLE, HOLD, RPT)
//   - STEP_*      : step_sel encodings
//   - step_value  : maps a step_sel code to its decimal step size
package freq_select_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RPT  = 2'd2
   } btn_state_t;

   localparam logic [1:0] STEP_1    = 2'd0;
   localparam logic [1:0] STEP_10   = 2'd1;
   localparam logic [1:0] STEP_100  = 2'd2;
   localparam logic [1:0] STEP_1000 = 2'd3;

   // Decimal step size selected by the front-panel step switches
   function automatic logic [15:0] step_value(input logic [1:0] sel);
      logic [15:0] val;
      case (sel)
         STEP_1:    val = 16'd1;
         STEP_10:   val = 16'd10;
         STEP_100:  val = 16'd100;
         STEP_1000: val = 16'd1000;
         default:   val = 16'd1;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/freq_select_btn_debounce.sv
// btn_debounce
//   Conditions one raw active-low pushbutton: 2-flop synchroniser, inversion
//   to active-high, and a stability counter that only lets the debounced
//   level follow the synchronised level after DB_CYCLES stable cycles.
//   Ports:
//     clk    - system clock
//     clr    - asynchronous active-low reset
//     raw_n  - raw button, active-low, asynchronous to clk
//     level  - debounced level, active-high (1 = pressed)
//     rise   - one-cycle pulse the cycle after level goes high
import freq_select_pkg::*;

module btn_debounce #(
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic clr,
   input  logic raw_n,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic          pressed;
   logic          armed;
   logic          level_d;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; loads "released" during reset
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= raw_n;
         sync_b <= sync_a;
      end
   end

   assign pressed = ~sync_b;

   // Debounce counter. After reset the button must first be seen released
   // for DB_CYCLES cycles (armed) before any press is accepted, so a button
   // held through reset cannot produce a step until it is let go and pressed
   // again. Once armed, the counter restarts whenever the synchronised level
   // agrees with the debounced one and flips the level when it expires.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         armed <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else if (!armed) begin
         if (pressed) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            armed <= 1'b1;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (pressed == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         level <= pressed;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Registered rising-edge detect on the debounced level
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         level_d <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_d <= level;
         rise    <= level & ~level_d;
      end
   end

endmodule

// File: rtl/freq_select.sv
// freq_select
//   Turns up/down pushbuttons and step switches into the decimal frequency
//   setpoint for the display and DDS tuning logic. Each button is debounced,
//   steps once on press, then auto-repeats while held. The result is kept in
//   [MIN_VAL, MAX_VAL].
//   Ports:
//     clk       - system clock
//     clr       - asynchronous active-low reset
//     btn_up_n  - raw up button, active-low
//     btn_dn_n  - raw down button, active-low
//     step_sel  - step size code (1, 10, 100, 1000)
//     dec       - current setpoint, binary
//     changed   - one-cycle pulse when dec takes a new value
//   Build option:
//     FREQ_SELECT_WRAP_EN - when defined the setpoint wraps at the bounds
//                           instead of saturating.
import freq_select_pkg::*;

module freq_select #(
   parameter int unsigned DB_CYCLES     = 500000,
   parameter int unsigned REPEAT_DELAY  = 25000000,
   parameter int unsigned REPEAT_PERIOD = 5000000,
   parameter int unsigned MIN_VAL       = 0,
   parameter int unsigned MAX_VAL       = 9999,
   parameter int unsigned INIT_VAL      = 1000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        btn_up_n,
   input  logic        btn_dn_n,
   input  logic [1:0]  step_sel,
   output logic [15:0] dec,
   output logic        changed
);

   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW = $clog2(RPT_MAX) + 1;
   localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [16:0] MIN17  = 17'(MIN_VAL);
   localparam logic [16:0] MAX17  = 17'(MAX_VAL);
   localparam logic [15:0] MIN16  = 16'(MIN_VAL);
   localparam logic [15:0] MAX16  = 16'(MAX_VAL);
   localparam logic [15:0] INIT16 = 16'(INIT_VAL);

   // Index 0 is the up button, index 1 the down button
   logic [1:0]    level;
   logic [1:0]    rise;
   logic [1:0]    req;
   logic          freeze;
   btn_state_t    state    [2];
   btn_state_t    state_nx [2];
   logic [CW-1:0] cnt      [2];
   logic [CW-1:0] cnt_nx   [2];

   logic [15:0]   step16;
   logic [16:0]   step17;
   logic [16:0]   dec17;
   logic [16:0]   sum17;
   logic [15:0]   dec_nx;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk   (clk),
      .clr   (clr),
      .raw_n (btn_up_n),
      .level (level[0]),
      .rise  (rise[0])
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
      .clk   (clk),
      .clr   (clr),
      .raw_n (btn_dn_n),
      .level (level[1]),
      .rise  (rise[1])
   );

   // With both buttons down, hold timers stop so neither side repeats;
   // presses from IDLE are still taken so simultaneous presses cancel.
   assign freeze = level[0] & level[1];

   // Button FSM state and hold-timer registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 2; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            state[i] <= state_nx[i];
            cnt[i]   <= cnt_nx[i];
         end
      end
   end

   // Button FSM next-state and step requests; a release always wins
   always_comb begin
      req = '0;
      for (int i = 0; i < 2; i++) begin
         state_nx[i] = state[i];
         cnt_nx[i]   = cnt[i];
         case (state[i])
            IDLE: begin
               if (rise[i] && level[i]) begin
                  req[i]      = 1'b1;
                  state_nx[i] = HOLD;
                  cnt_nx[i]   = '0;
               end
            end
            HOLD: begin
               if (!level[i]) begin
                  state_nx[i] = IDLE;
               end else if (!freeze) begin
                  if (cnt[i] == DELAY_LAST) begin
                     req[i]      = 1'b1;
                     state_nx[i] = RPT;
                     cnt_nx[i]   = '0;
                  end else begin
                     cnt_nx[i] = cnt[i] + 1'b1;
                  end
               end
            end
            RPT: begin
               if (!level[i]) begin
                  state_nx[i] = IDLE;
               end else if (!freeze) begin
                  if (cnt[i] == PERIOD_LAST) begin
                     req[i]    = 1'b1;
                     cnt_nx[i] = '0;
                  end else begin
                     cnt_nx[i] = cnt[i] + 1'b1;
                  end
               end
            end
            default: begin
               state_nx[i] = IDLE;
               cnt_nx[i]   = '0;
            end
         endcase
      end
   end

   // Setpoint arithmetic in 17 bits so the up-sum cannot overflow before
   // the bound check; opposing requests in one cycle cancel.
   always_comb begin
      step16 = step_value(step_sel);
      step17 = {1'b0, step16};
      dec17  = {1'b0, dec};
      sum17  = dec17 + step17;
      dec_nx = dec;
      if (req == 2'b01) begin
         if (sum17 > MAX17) begin
`ifdef FREQ_SELECT_WRAP_EN
            dec_nx = MIN16;
`else
            dec_nx = MAX16;
`endif
         end else begin
            dec_nx = sum17[15:0];
         end
      end else if (req == 2'b10) begin
         if (dec17 < (MIN17 + step17)) begin
`ifdef FREQ_SELECT_WRAP_EN
            dec_nx = MAX16;
`else
            dec_nx = MIN16;
`endif
         end else begin
            dec_nx = dec - step16;
         end
      end
   end

   // Setpoint register; changed only flags a real move of the value
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         dec     <= INIT16;
         changed <= 1'b0;
      end else begin
         dec     <= dec_nx;
         changed <= (dec_nx != dec);
      end
   end

endmodule

// File: tb/tb_freq_select.sv
// tb_freq_select
//   Directed bench for freq_select with short debounce and repeat timings.
//   A table of single presses from reset covers every step size in both
//   directions; hand-written sequences cover latency, bounce rejection,
//   auto-repeat, bounds, simultaneous presses and reset while held.
import freq_select_pkg::*;

module tb_freq_select;

   logic        clk = 1'b0;
   logic        clr;
   logic        btn_up_n;
   logic        btn_dn_n;
   logic [1:0]  step_sel;
   logic [15:0] dec;
   logic        changed;

   int checks    = 0;
   int passes    = 0;
   int pulse_cnt = 0;
   int p0;

   typedef struct {
      bit         up;
      logic [1:0] sel;
      int         exp_dec;
   } vec_t;

   vec_t vecs [8];

   freq_select #(
      .DB_CYCLES     (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5),
      .MIN_VAL       (0),
      .MAX_VAL       (9999),
      .INIT_VAL      (1000)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .btn_up_n (btn_up_n),
      .btn_dn_n (btn_dn_n),
      .step_sel (step_sel),
      .dec      (dec),
      .changed  (changed)
   );

   always #5 clk = ~clk;

   // Count changed pulses, sampled on the falling edge
   always @(negedge clk) begin
      if (changed === 1'b1) pulse_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic do_reset();
      clr = 1'b0;
      tick(2);
      clr = 1'b1;
      tick(10);
   endtask

   // One clean press held for 'hold' cycles, then released and settled
   task automatic applyStimulus(input bit up, input logic [1:0] sel, input int hold);
      step_sel = sel;
      if (up) btn_up_n = 1'b0;
      else    btn_dn_n = 1'b0;
      tick(hold);
      btn_up_n = 1'b1;
      btn_dn_n = 1'b1;
      tick(14);
   endtask

   initial begin
      clr      = 1'b0;
      btn_up_n = 1'b1;
      btn_dn_n = 1'b1;
      step_sel = STEP_1;

      vecs[0] = '{1'b1, STEP_1,    1001};
      vecs[1] = '{1'b1, STEP_10,   1010};
      vecs[2] = '{1'b1, STEP_100,  1100};
      vecs[3] = '{1'b1, STEP_1000, 2000};
      vecs[4] = '{1'b0, STEP_1,    999};
      vecs[5] = '{1'b0, STEP_10,   990};
      vecs[6] = '{1'b0, STEP_100,  900};
      vecs[7] = '{1'b0, STEP_1000, 0};

      // Reset state and exact press latency (2 sync + 4 debounce + 2)
      do_reset();
      checkOutput("reset_dec", dec, 1000);
      checkOutput("reset_changed", changed, 0);
      step_sel = STEP_10;
      p0 = pulse_cnt;
      btn_up_n = 1'b0;
      tick(7);
      checkOutput("latency_before", dec, 1000);
      tick(1);
      checkOutput("latency_dec", dec, 1010);
      checkOutput("latency_changed", changed, 1);
      tick(1);
      checkOutput("changed_one_cycle", changed, 0);
      tick(1);
      btn_up_n = 1'b1;
      tick(30);
      checkOutput("single_no_repeat", dec, 1010);
      checkOutput("single_pulses", pulse_cnt - p0, 1);

      // Table of single presses from reset
      for (int i = 0; i < 8; i++) begin
         do_reset();
         p0 = pulse_cnt;
         applyStimulus(vecs[i].up, vecs[i].sel, 10);
         checkOutput($sformatf("vec%0d_dec", i), dec, vecs[i].exp_dec);
         checkOutput($sformatf("vec%0d_pulses", i), pulse_cnt - p0, 1);
      end

      // Bouncy down press: only the final stable low counts
      do_reset();
      step_sel = STEP_1;
      p0 = pulse_cnt;
      for (int i = 0; i < 3; i++) begin
         btn_dn_n = 1'b0;
         tick(2);
         btn_dn_n = 1'b1;
         tick(2);
      end
      checkOutput("bounce_rejected", dec, 1000);
      btn_dn_n = 1'b0;
      tick(8);
      btn_dn_n = 1'b1;
      tick(30);
      checkOutput("bounce_dec", dec, 999);
      checkOutput("bounce_pulses", pulse_cnt - p0, 1);

      // Held up button: steps at press, +20, then every 5
      do_reset();
      step_sel = STEP_100;
      p0 = pulse_cnt;
      btn_up_n = 1'b0;
      tick(8);
      checkOutput("hold_first", dec, 1100);
      tick(19);
      checkOutput("hold_before_repeat", dec, 1100);
      tick(1);
      checkOutput("hold_repeat_delay", dec, 1200);
      tick(5);
      checkOutput("hold_repeat_period", dec, 1300);
      tick(27);
      btn_up_n = 1'b1;
      tick(20);
      checkOutput("hold_final", dec, 1900);
      checkOutput("hold_pulses", pulse_cnt - p0, 9);

      // Both pressed together cancel; up repeats once down is released
      do_reset();
      step_sel = STEP_10;
      p0 = pulse_cnt;
      btn_up_n = 1'b0;
      btn_dn_n = 1'b0;
      tick(8);
      checkOutput("both_cancel", dec, 1000);
      tick(32);
      checkOutput("both_frozen", dec, 1000);
      checkOutput("both_no_pulse", pulse_cnt - p0, 0);
      btn_dn_n = 1'b1;
      tick(25);
      checkOutput("resume_before", dec, 1000);
      tick(1);
      checkOutput("resume_step", dec, 1010);
      checkOutput("resume_changed", changed, 1);
      tick(5);
      checkOutput("resume_repeat", dec, 1020);
      btn_up_n = 1'b1;
      tick(20);
      checkOutput("resume_final", dec, 1030);
      checkOutput("resume_pulses", pulse_cnt - p0, 3);

      // Upper bound
      do_reset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, STEP_1000, 10);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, STEP_100, 10);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, STEP_10, 10);
      checkOutput("climb_dec", dec, 9950);
      p0 = pulse_cnt;
      applyStimulus(1'b1, STEP_100, 10);
      checkOutput("upper_clip_dec", dec, 9999);
      checkOutput("upper_clip_pulses", pulse_cnt - p0, 1);
      p0 = pulse_cnt;
      applyStimulus(1'b1, STEP_100, 10);
`ifdef FREQ_SELECT_WRAP_EN
      checkOutput("upper_bound_dec", dec, 0);
      checkOutput("upper_bound_pulses", pulse_cnt - p0, 1);
`else
      checkOutput("upper_bound_dec", dec, 9999);
      checkOutput("upper_bound_pulses", pulse_cnt - p0, 0);
`endif

      // Lower bound
      do_reset();
      applyStimulus(1'b0, STEP_1000, 10);
      checkOutput("lower_reach_dec", dec, 0);
      p0 = pulse_cnt;
      applyStimulus(1'b0, STEP_1, 10);
`ifdef FREQ_SELECT_WRAP_EN
      checkOutput("lower_bound_dec", dec, 9999);
      checkOutput("lower_bound_pulses", pulse_cnt - p0, 1);
`else
      checkOutput("lower_bound_dec", dec, 0);
      checkOutput("lower_bound_pulses", pulse_cnt - p0, 0);
`endif

      // Reset while auto-repeating, button kept held through release
      do_reset();
      step_sel = STEP_100;
      btn_up_n = 1'b0;
      tick(43);
      checkOutput("rpt_reached", dec, 1500);
      tick(2);
      clr = 1'b0;
      #1;
      checkOutput("async_reset_dec", dec, 1000);
      checkOutput("async_reset_changed", changed, 0);
      p0 = pulse_cnt;
      tick(3);
      clr = 1'b1;
      tick(40);
      checkOutput("held_after_reset_dec", dec, 1000);
      checkOutput("held_after_reset_pulses", pulse_cnt - p0, 0);
      btn_up_n = 1'b1;
      tick(15);
      applyStimulus(1'b1, STEP_100, 10);
      checkOutput("repress_dec", dec, 1100);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
